// File: rtl/dbchecker_pkg.sv
// Shared types and AXI/DBTE constants for the DBTE fetch arbiter.
package dbchecker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RSP  = 2'd3
  } fetch_state_t;

  localparam int unsigned DBTE_BYTES     = 16;
  localparam logic [2:0]  DBTE_SIZE      = 3'd4;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the requester
// that was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dbte_fetch_arbiter.sv
// Shares the DBTE AXI read master between the read and write bound checkers.
// Optional per-requester entry cache: define DBTE_FETCH_CACHE_EN.
module dbte_fetch_arbiter
  import dbchecker_pkg::*;
#(
  parameter int unsigned ADDR_W = 48,
  parameter int unsigned IDX_W  = 12,
  parameter int unsigned DATA_W = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   tbl_base,
  input  logic                tbl_en,
  input  logic                inv,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*IDX_W-1:0]  req_idx,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   m_axi_dbte_araddr,
  output logic [7:0]          m_axi_dbte_arlen,
  output logic [2:0]          m_axi_dbte_arsize,
  output logic [1:0]          m_axi_dbte_arburst,
  output logic                m_axi_dbte_arvalid,
  input  logic                m_axi_dbte_arready,
  input  logic [DATA_W-1:0]   m_axi_dbte_rdata,
  input  logic [1:0]          m_axi_dbte_rresp,
  input  logic                m_axi_dbte_rlast,
  input  logic                m_axi_dbte_rvalid,
  output logic                m_axi_dbte_rready
);

  localparam int unsigned OFS_W = $clog2(DBTE_BYTES);

  fetch_state_t      state, state_nx;
  logic [1:0]        gnt;
  logic              g_q, last_grant;
  logic [IDX_W-1:0]  idx_sel;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, hit_data;
  logic              err_q, first_q;
  logic              hs, hit, beat, beat_err, done;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign req_ready = (state == IDLE) ? gnt : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign idx_sel   = gnt[1] ? req_idx[IDX_W +: IDX_W] : req_idx[0 +: IDX_W];
  assign beat      = (state == R) && m_axi_dbte_rvalid;
  // A beat without rlast means the slave returned more than the single beat asked for.
  assign beat_err  = (m_axi_dbte_rresp != AXI_RESP_OKAY) || !m_axi_dbte_rlast;
  assign done      = beat && m_axi_dbte_rlast;

`ifdef DBTE_FETCH_CACHE_EN
  logic [1:0]        c_valid;
  logic [IDX_W-1:0]  c_tag  [2];
  logic [DATA_W-1:0] c_data [2];
  logic [IDX_W-1:0]  idx_q;
  logic              fill;

  assign hit      = c_valid[gnt[1]] && (c_tag[gnt[1]] == idx_sel) && tbl_en;
  assign hit_data = c_data[gnt[1]];
  assign fill     = done && !err_q && !beat_err;

  // One entry per requester; an invalidate overrides a fill in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_valid   <= 2'b00;
      idx_q     <= '0;
      c_tag[0]  <= '0;
      c_tag[1]  <= '0;
      c_data[0] <= '0;
      c_data[1] <= '0;
    end else begin
      if (hs) idx_q <= idx_sel;
      if (fill) begin
        c_valid[g_q] <= 1'b1;
        c_tag[g_q]   <= idx_q;
        c_data[g_q]  <= m_axi_dbte_rdata;
      end
      if (inv) c_valid <= 2'b00;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign hit        = 1'b0;
  assign hit_data   = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (hs) state_nx = (!tbl_en || hit) ? RSP : AR;
      AR:      if (m_axi_dbte_arready) state_nx = R;
      R:       if (done) state_nx = RSP;
      RSP:     if (rsp_ready[g_q]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Transaction context: granted requester, address, and the response payload.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      g_q        <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      if (hs) begin
        g_q     <= gnt[1];
        addr_q  <= tbl_base + (ADDR_W'(idx_sel) << OFS_W);
        first_q <= 1'b1;
        err_q   <= !tbl_en;
        if (!tbl_en)  data_q <= '0;
        else if (hit) data_q <= hit_data;
      end
      if (beat) begin
        first_q <= 1'b0;
        err_q   <= err_q | beat_err;
        if (first_q) data_q <= beat_err ? '0 : m_axi_dbte_rdata;
      end
      if (state == RSP && rsp_ready[g_q]) last_grant <= g_q;
    end
  end

  assign m_axi_dbte_arvalid = (state == AR);
  assign m_axi_dbte_araddr  = addr_q;
  assign m_axi_dbte_arlen   = 8'd0;
  assign m_axi_dbte_arsize  = m_axi_dbte_arvalid ? DBTE_SIZE : 3'd0;
  assign m_axi_dbte_arburst = m_axi_dbte_arvalid ? AXI_BURST_INCR : 2'b00;
  assign m_axi_dbte_rready  = (state == R);
  assign rsp_valid          = (state == RSP) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data           = (state == RSP) ? data_q : '0;
  assign rsp_err            = (state == RSP) && err_q;

endmodule

// File: doc/dbte_fetch_arbiter.md
# dbte_fetch_arbiter

Shares the single DBTE read master (m_axi_dbte) between the DBChecker's read-path and write-path bound checkers. Accepts one table-index lookup at a time from two requesters and grants them round-robin. Issues a single-beat 128-bit AXI read at tbl_base + idx*16 and returns the entry, or an error, to the granted requester. Sits between the checker pipelines and the m_axi_dbte port of DBChecker.

## Interface
Parameters:
- ADDR_W, 48, DBTE master address width
- IDX_W, 12, DBTE index width
- DATA_W, 128, DBTE entry and R data width

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- tbl_base  in  ADDR_W  table base address, from control register
- tbl_en  in  1  table enabled; 0 forces error responses
- inv  in  1  single-cycle pulse; invalidates cached entries (cache build only)
- req_valid  in  2  lookup request, bit0 = read checker, bit1 = write checker
- req_ready  out  2  request accepted
- req_idx  in  2*IDX_W  index, requester n at [n*IDX_W +: IDX_W]
- rsp_valid  out  2  response valid toward requester n
- rsp_ready  in  2  requester n takes response
- rsp_data  out  DATA_W  entry, shared by both requesters
- rsp_err  out  1  lookup failed
- m_axi_dbte_araddr/arlen/arsize/arburst/arvalid  out  ADDR_W/8/3/2/1  AR channel
- m_axi_dbte_arready  in  1
- m_axi_dbte_rdata/rresp/rlast/rvalid  in  DATA_W/2/1/1  R channel
- m_axi_dbte_rready  out  1
- The instantiating module ties the remaining AR fields and the whole write channel.

## Operation
- FSM states: IDLE, AR, R, RSP.
- IDLE:
  - req_ready[g]=1 only for the granted requester g.
  - One request: it wins. Both: the requester not equal to last_grant wins.
  - On handshake, latch g and idx.
  - tbl_en=0 → RSP with rsp_err=1, rsp_data=0, no AXI traffic.
  - Otherwise (cache miss) → AR.
- AR:
  - arvalid=1, araddr = (tbl_base + {idx,4'b0}) truncated to ADDR_W (wraps), arlen=0, arsize=4, arburst=INCR.
  - araddr is held stable until arready. On arready → R.
- R:
  - rready=1. On rvalid, capture rdata; err = (rresp!=OKAY) | !rlast.
  - If rlast=0, keep draining beats; on the first data beat, latch data, or 0 if err. Leave on the beat with rlast=1 → RSP.
- RSP: rsp_valid[g]=1, other bit 0. On rsp_ready[g] → IDLE, last_grant<=g.
- Only one transaction is outstanding; ID is not used.
- Reset values: all outputs 0, state IDLE, last_grant=1 so requester 0 wins the first tie, cache valids 0.
- Reset mid-transaction abandons the AXI transfer; the system resets the interconnect on the same reset.
- tbl_base/tbl_en changes are sampled only at the IDLE handshake.

## Timing
- Miss, zero-wait slave:
  - req handshake in cycle 0.
  - arvalid in cycle 1 (arready same cycle).
  - rready in cycle 2 (rvalid same cycle).
  - rsp_valid in cycle 3.
- Each AR/R stall cycle adds one cycle.
- Hit (cache build) or tbl_en=0: rsp_valid in cycle 1.
- Response hold: rsp_valid, rsp_data and rsp_err stay stable until rsp_ready.
- Back-to-back: next grant the cycle after leaving RSP. No request is accepted in the RSP exit cycle.

## Configuration
- DBTE_FETCH_CACHE_EN defined:
  - One entry per requester: valid, IDX_W tag, DATA_W data.
  - Hit = valid & tag==idx & tbl_en at handshake → RSP with cached data, rsp_err=0.
  - Fill on any error-free AXI response.
  - inv clears both valids. inv in the same cycle as a fill: inv wins, valid=0.
- Undefined: no cache storage; every enabled lookup issues an AXI read; inv ignored.

## Structure
- dbchecker_pkg holds:
  - state enum
  - DBTE_BYTES=16, DBTE_SIZE=3'd4
  - AXI_BURST_INCR=2'b01
  - AXI_RESP_OKAY=2'b00
- Sub-module rr_arb2: two-way round-robin grant from req[1:0] and last_grant.

## Test plan
- Single miss: tbl_base=0x1000, req0 idx=3 → araddr=0x1030, arlen=0, arsize=4; rdata=K, rresp=OKAY → rsp_valid=2'b01, rsp_data=K, rsp_err=0 in cycle 3.
- Contention: req0 and req1 held valid from reset → grants 0,1,0,1; araddr order follows.
- Errors:
  - rresp=SLVERR → rsp_err=1, rsp_data=0.
  - rlast=0 on first beat then rlast=1 → one rsp, rsp_err=1, no extra AR.
- tbl_en=0, req1 idx=5 → no arvalid, rsp_valid=2'b10, rsp_err=1 at cycle 1.
- Wrap and backpressure: tbl_base=0xFFFF_FFFF_FFF0, idx=1 → araddr=0. arready low 4 cycles → araddr stable throughout. rsp_ready low 3 cycles → rsp held.
- DBTE_FETCH_CACHE_EN:
  - Repeat idx=3 on req0 → no AR, rsp_valid at cycle 1 with cached data.
  - inv, then repeat → AR reissued.
  - inv coincident with fill → next lookup misses.
